i2s_apb_sequencer: RTL and testbench

APB master that sequences the I2S transceiver's register interface from a single `pclk` domain.

- Writes the configuration word, then polls the status register.
- Moves audio samples between a streaming source/sink pair and the transceiver's Tx/Rx data registers, with round-robin arbitration between Tx and Rx service.
- Sits between the system sample streams and the `I2S_top` APB slave port; on a stop request, rewrites the configuration with the stop bit set.

---
 rtl/i2s_apb_sequencer.sv | 163 ++++++++++++++++
 tb/tb_i2s_apb_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/i2s_apb_sequencer.sv
// APB master for the I2S transceiver: configures it, polls status, and moves
// samples between the Tx source / Rx sink streams and the data registers.
module i2s_apb_sequencer #(
  parameter logic [31:0] ADDR_CTRL = 32'h0000_0000,
  parameter logic [31:0] ADDR_STAT = 32'h0000_0004,
  parameter logic [31:0] ADDR_TX   = 32'h0000_0008,
  parameter logic [31:0] ADDR_RX   = 32'h0000_000C,
  parameter int unsigned STOP_BIT  = 0
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic [31:0] cfg_word,
  input  logic        start,
  input  logic        stop_req,
  input  logic        tx_valid,
  input  logic [31:0] tx_data,
  output logic        tx_ready,
  output logic        rx_valid,
  output logic [31:0] rx_data,
  input  logic        rx_ready,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  output logic        busy,
  output logic        rx_overflow,
  output logic [15:0] tx_count,
  output logic [15:0] rx_count
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 16;
  localparam logic [DW-1:0] STOP_MASK = DW'(1) << STOP_BIT;

  typedef enum logic [3:0] {
    IDLE, CFG_S, CFG_A, POLL_S, POLL_A, DECIDE,
    TX_S, TX_A, RX_S, RX_A, STOP_S, STOP_A
  } state_t;

  state_t        state;
  logic [DW-1:0] cfg_q;
  logic [3:0]    stat_q;   // {Tx_full, Tx_empty, Rx_full, Rx_empty}
  logic          stop_q;
  logic          last_tx;  // 1: Tx was granted last, 0: Rx

  logic stop_pend, tx_elig, rx_elig, grant_tx, grant_rx;

  // Grant decision; a stop request arriving in DECIDE itself still wins
  always_comb begin
    stop_pend = stop_q | stop_req;
    tx_elig   = tx_valid & ~stat_q[3];
    rx_elig   = ~stat_q[0] & ~rx_valid;
    grant_tx  = tx_elig & (~rx_elig | ~last_tx);
    grant_rx  = rx_elig & (~tx_elig | last_tx);
  end

  // Accept strobe must coincide with the DECIDE cycle that captures tx_data
  assign tx_ready = (state == DECIDE) & ~stop_pend & grant_tx;

  always_ff @(posedge pclk) begin
    if (!preset) begin
      state       <= IDLE;
      cfg_q       <= '0;
      stat_q      <= '0;
      stop_q      <= 1'b0;
      last_tx     <= 1'b0;
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      rx_valid    <= 1'b0;
      rx_data     <= '0;
      busy        <= 1'b0;
      rx_overflow <= 1'b0;
      tx_count    <= '0;
      rx_count    <= '0;
    end else begin
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (stop_req && state != IDLE) stop_q <= 1'b1;

      case (state)
        IDLE: if (start) begin
          state       <= CFG_S;
          cfg_q       <= cfg_word & ~STOP_MASK;
          psel        <= 1'b1;
          penable     <= 1'b0;
          pwrite      <= 1'b1;
          paddr       <= ADDR_CTRL;
          pwdata      <= cfg_word & ~STOP_MASK;
          busy        <= 1'b1;
          rx_overflow <= 1'b0;
          tx_count    <= '0;
          rx_count    <= '0;
        end
        CFG_S:  begin state <= CFG_A;  penable <= 1'b1; end
        POLL_S: begin state <= POLL_A; penable <= 1'b1; end
        TX_S:   begin state <= TX_A;   penable <= 1'b1; end
        RX_S:   begin state <= RX_A;   penable <= 1'b1; end
        STOP_S: begin state <= STOP_A; penable <= 1'b1; end
        CFG_A, TX_A, RX_A: begin
          state   <= POLL_S;
          penable <= 1'b0;
          pwrite  <= 1'b0;
          paddr   <= ADDR_STAT;
          if (state == TX_A) tx_count <= tx_count + CW'(1);
          if (state == RX_A) begin
            rx_data  <= prdata;
            rx_valid <= 1'b1;
            rx_count <= rx_count + CW'(1);
          end
        end
        POLL_A: begin
          state   <= DECIDE;
          stat_q  <= prdata[3:0];
          psel    <= 1'b0;
          penable <= 1'b0;
          if (prdata[1]) rx_overflow <= 1'b1;
        end
        DECIDE: begin
          psel <= 1'b1;
          if (stop_pend) begin
            state  <= STOP_S;
            pwrite <= 1'b1;
            paddr  <= ADDR_CTRL;
            pwdata <= cfg_q | STOP_MASK;
          end else if (grant_tx) begin
            state   <= TX_S;
            pwrite  <= 1'b1;
            paddr   <= ADDR_TX;
            pwdata  <= tx_data;
            last_tx <= 1'b1;
          end else if (grant_rx) begin
            state   <= RX_S;
            pwrite  <= 1'b0;
            paddr   <= ADDR_RX;
            last_tx <= 1'b0;
          end else begin
            state  <= POLL_S;
            pwrite <= 1'b0;
            paddr  <= ADDR_STAT;
          end
        end
        STOP_A: begin
          state   <= IDLE;
          stop_q  <= 1'b0;
          psel    <= 1'b0;
          penable <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          psel    <= 1'b0;
          penable <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_apb_sequencer.sv
// Directed bench for i2s_apb_sequencer with a behavioural APB slave
// returning bench-chosen status and Rx data words.
module tb_i2s_apb_sequencer;

  localparam logic [31:0] A_CTRL = 32'h0000_0000;
  localparam logic [31:0] A_STAT = 32'h0000_0004;
  localparam logic [31:0] A_TX   = 32'h0000_0008;
  localparam logic [31:0] A_RX   = 32'h0000_000C;

  logic        pclk, preset;
  logic [31:0] cfg_word;
  logic        start, stop_req;
  logic        tx_valid;
  logic [31:0] tx_data;
  logic        tx_ready;
  logic        rx_valid;
  logic [31:0] rx_data;
  logic        rx_ready;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic        busy, rx_overflow;
  logic [15:0] tx_count, rx_count;

  logic [3:0]  stat_val;
  logic [31:0] rx_val;

  int checks = 0;
  int passed = 0;

  i2s_apb_sequencer dut (
    .pclk(pclk), .preset(preset), .cfg_word(cfg_word), .start(start),
    .stop_req(stop_req), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .busy(busy),
    .rx_overflow(rx_overflow), .tx_count(tx_count), .rx_count(rx_count)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  always_comb begin
    if (paddr == A_STAT)    prdata = {28'h0, stat_val};
    else if (paddr == A_RX) prdata = rx_val;
    else                    prdata = 32'h0;
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge pclk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    preset = 1'b0; start = 1'b0; stop_req = 1'b0; cfg_word = 32'h0;
    tx_valid = 1'b0; tx_data = 32'h0; rx_ready = 1'b0;
    stat_val = 4'b0101; rx_val = 32'h0;
    tick(2);
    check("rst_psel", 32'(psel), 32'd0);
    check("rst_penable", 32'(penable), 32'd0);
    check("rst_pwrite", 32'(pwrite), 32'd0);
    check("rst_paddr", paddr, 32'h0);
    check("rst_pwdata", pwdata, 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_tx_count", 32'(tx_count), 32'd0);
    check("rst_overflow", 32'(rx_overflow), 32'd0);
    check("rst_tx_ready", 32'(tx_ready), 32'd0);

    // Configuration write then status poll
    preset = 1'b1; cfg_word = 32'h0000_00A2; start = 1'b1;
    tick(); start = 1'b0;
    check("cfg_s_psel", 32'(psel), 32'd1);
    check("cfg_s_penable", 32'(penable), 32'd0);
    check("cfg_s_pwrite", 32'(pwrite), 32'd1);
    check("cfg_s_paddr", paddr, A_CTRL);
    check("cfg_s_pwdata", pwdata, 32'h0000_00A2);
    check("cfg_busy", 32'(busy), 32'd1);
    tick();
    check("cfg_a_penable", 32'(penable), 32'd1);
    tick();
    check("poll_s_paddr", paddr, A_STAT);
    check("poll_s_pwrite", 32'(pwrite), 32'd0);
    check("poll_s_penable", 32'(penable), 32'd0);
    tick(2);
    check("decide_psel", 32'(psel), 32'd0);

    // Tx stream: two samples, writes 5 cycles apart
    tx_valid = 1'b1; tx_data = 32'h0000_1111; #1;
    check("tx1_ready", 32'(tx_ready), 32'd1);
    tick();
    check("tx1_paddr", paddr, A_TX);
    check("tx1_pwdata", pwdata, 32'h0000_1111);
    check("tx1_ready_low", 32'(tx_ready), 32'd0);
    tx_data = 32'h0000_2222;
    tick(2);
    check("tx_count_1", 32'(tx_count), 32'd1);
    tick(2);
    check("tx2_ready", 32'(tx_ready), 32'd1);
    tick();
    check("tx2_paddr", paddr, A_TX);
    check("tx2_pwdata", pwdata, 32'h0000_2222);
    tx_valid = 1'b0;
    tick(2);
    check("tx_count_2", 32'(tx_count), 32'd2);

    // Arbitration from reset: Tx, Rx, Tx, Rx
    preset = 1'b0; tick(); preset = 1'b1;
    check("rst2_tx_count", 32'(tx_count), 32'd0);
    stat_val = 4'b0000; tx_valid = 1'b1; tx_data = 32'h0000_3333;
    rx_ready = 1'b1; rx_val = 32'hCAFE_0001; start = 1'b1;
    tick(); start = 1'b0;
    tick(4);
    check("arb1_tx_ready", 32'(tx_ready), 32'd1);
    tick(5);
    check("arb2_tx_ready", 32'(tx_ready), 32'd0);
    tick();
    check("arb2_paddr", paddr, A_RX);
    check("arb2_pwrite", 32'(pwrite), 32'd0);
    tick(2);
    check("arb2_rx_valid", 32'(rx_valid), 32'd1);
    check("arb2_rx_data", rx_data, 32'hCAFE_0001);
    check("arb2_rx_count", 32'(rx_count), 32'd1);
    rx_val = 32'hCAFE_0002;
    tick();
    check("arb2_consumed", 32'(rx_valid), 32'd0);
    tick();
    check("arb3_tx_ready", 32'(tx_ready), 32'd1);
    tick(5);
    check("arb4_tx_ready", 32'(tx_ready), 32'd0);
    tick(3);
    check("arb4_rx_data", rx_data, 32'hCAFE_0002);
    check("arb4_rx_count", 32'(rx_count), 32'd2);
    check("arb_tx_count", 32'(tx_count), 32'd2);

    // Backpressure: Tx full, sink stalled -> idle poll loop, overflow flagged
    rx_ready = 1'b0; stat_val = 4'b1011;
    tick(2);
    check("bp_tx_ready", 32'(tx_ready), 32'd0);
    tick();
    check("bp_poll1_psel", 32'(psel), 32'd1);
    check("bp_poll1_paddr", paddr, A_STAT);
    check("bp_overflow", 32'(rx_overflow), 32'd1);
    tick(2);
    check("bp_decide_psel", 32'(psel), 32'd0);
    tick();
    check("bp_poll2_psel", 32'(psel), 32'd1);
    check("bp_poll2_penable", 32'(penable), 32'd0);
    check("bp_poll2_paddr", paddr, A_STAT);
    check("bp_tx_count", 32'(tx_count), 32'd2);
    check("bp_rx_count", 32'(rx_count), 32'd2);
    check("bp_rx_valid", 32'(rx_valid), 32'd1);

    // Stop during TX_A: transfer completes, stop wins next DECIDE
    stat_val = 4'b0101; tx_data = 32'h0000_4444;
    tick(2);
    check("stop_tx_ready", 32'(tx_ready), 32'd1);
    tick();
    check("stop_tx_pwdata", pwdata, 32'h0000_4444);
    tick();
    stop_req = 1'b1;
    tick(); stop_req = 1'b0;
    check("stop_tx_count", 32'(tx_count), 32'd3);
    check("stop_poll_paddr", paddr, A_STAT);
    tick(2);
    check("stop_wins_tx_ready", 32'(tx_ready), 32'd0);
    tick();
    check("stop_s_paddr", paddr, A_CTRL);
    check("stop_s_pwdata", pwdata, 32'h0000_00A3);
    check("stop_s_pwrite", 32'(pwrite), 32'd1);
    check("stop_s_penable", 32'(penable), 32'd0);
    tick();
    check("stop_a_penable", 32'(penable), 32'd1);
    tick();
    check("stop_idle_busy", 32'(busy), 32'd0);
    check("stop_idle_psel", 32'(psel), 32'd0);
    check("stop_rx_kept", 32'(rx_valid), 32'd1);
    check("stop_rx_data", rx_data, 32'hCAFE_0002);

    // Reset in the middle of an Rx read
    rx_ready = 1'b1; tx_valid = 1'b0; stat_val = 4'b0100; rx_val = 32'h0000_5555;
    start = 1'b1;
    tick(); start = 1'b0;
    check("restart_tx_count", 32'(tx_count), 32'd0);
    check("restart_overflow", 32'(rx_overflow), 32'd0);
    check("restart_rx_valid", 32'(rx_valid), 32'd0);
    tick(5);
    check("mid_rx_paddr", paddr, A_RX);
    check("mid_rx_psel", 32'(psel), 32'd1);
    preset = 1'b0;
    tick();
    check("rstrx_psel", 32'(psel), 32'd0);
    check("rstrx_penable", 32'(penable), 32'd0);
    check("rstrx_paddr", paddr, 32'h0);
    check("rstrx_pwdata", pwdata, 32'h0);
    check("rstrx_busy", 32'(busy), 32'd0);
    check("rstrx_rx_valid", 32'(rx_valid), 32'd0);
    check("rstrx_rx_data", rx_data, 32'h0);
    check("rstrx_rx_count", 32'(rx_count), 32'd0);
    preset = 1'b1;
    tick(2);
    check("rstrx_idle_psel", 32'(psel), 32'd0);
    check("rstrx_idle_rx_count", 32'(rx_count), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
